// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port synchronous RAM between two requesters.
// Requester A is the boot loader, requester B is the core/scan path.
// Each access is IDLE -> ACCESS (one-cycle strobe + grant) -> READ (reads only)
// -> IDLE, with round-robin arbitration performed only in IDLE.
// Optional feature: define RAM_ARB_BOOT_LOCK_EN to make B ineligible while
// boot=1 is seen at the arbitration edge; otherwise boot is ignored.
module ram_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              boot,
    // requester A (boot loader)
    input  logic              a_req,
    input  logic              a_rw,
    input  logic [ADDR_W-1:0] a_adr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_valid,
    output logic [DATA_W-1:0] a_rdata,
    // requester B (core/scan)
    input  logic              b_req,
    input  logic              b_rw,
    input  logic [ADDR_W-1:0] b_adr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_valid,
    output logic [DATA_W-1:0] b_rdata,
    // RAM side
    output logic              ram_enable,
    output logic              ram_rw,
    output logic [ADDR_W-1:0] ram_adr,
    output logic [DATA_W-1:0] ram_in,
    input  logic [DATA_W-1:0] ram_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        READ   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                prio_a_q, prio_a_d;    // 1: A wins a simultaneous request
    logic                win_b_q, win_b_d;      // owner of the access in flight
    logic                a_gnt_q, a_gnt_d;
    logic                b_gnt_q, b_gnt_d;
    logic                a_valid_q, a_valid_d;
    logic                b_valid_q, b_valid_d;
    logic [DATA_W-1:0]   a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0]   b_rdata_q, b_rdata_d;
    logic                ram_enable_q, ram_enable_d;
    // The RAM command registers double as the latched winner command:
    // loaded when leaving IDLE, held otherwise.
    logic                ram_rw_q, ram_rw_d;
    logic [ADDR_W-1:0]   ram_adr_q, ram_adr_d;
    logic [DATA_W-1:0]   ram_in_q, ram_in_d;

    logic                b_eligible;
    logic                grant_a;
    logic                grant_b;

`ifndef RAM_ARB_BOOT_LOCK_EN
    // boot has no function in this build
    logic unused_boot;
    assign unused_boot = boot;
`endif

    // Decide which requester would win if the arbiter sampled this cycle
    always_comb begin
`ifdef RAM_ARB_BOOT_LOCK_EN
        b_eligible = b_req & ~boot;
`else
        b_eligible = b_req;
`endif
        grant_a = a_req & (~b_eligible | prio_a_q);
        grant_b = b_eligible & (~a_req | ~prio_a_q);
    end

    // Next-state and registered-output computation for the access sequencer
    always_comb begin
        state_d      = state_q;
        prio_a_d     = prio_a_q;
        win_b_d      = win_b_q;
        a_gnt_d      = 1'b0;
        b_gnt_d      = 1'b0;
        a_valid_d    = 1'b0;
        b_valid_d    = 1'b0;
        a_rdata_d    = a_rdata_q;
        b_rdata_d    = b_rdata_q;
        ram_enable_d = 1'b0;
        ram_rw_d     = ram_rw_q;
        ram_adr_d    = ram_adr_q;
        ram_in_d     = ram_in_q;

        case (state_q)
            IDLE: begin
                if (grant_a || grant_b) begin
                    state_d      = ACCESS;
                    win_b_d      = grant_b;
                    // the port just served loses the next tie
                    prio_a_d     = grant_b;
                    a_gnt_d      = grant_a;
                    b_gnt_d      = grant_b;
                    ram_enable_d = 1'b1;
                    if (grant_b) begin
                        ram_rw_d  = b_rw;
                        ram_adr_d = b_adr;
                        ram_in_d  = b_wdata;
                    end else begin
                        ram_rw_d  = a_rw;
                        ram_adr_d = a_adr;
                        ram_in_d  = a_wdata;
                    end
                end
            end

            ACCESS: begin
                // strobe is live this cycle; reads need one more cycle for ram_out
                state_d = ram_rw_q ? IDLE : READ;
            end

            READ: begin
                state_d = IDLE;
                if (win_b_q) begin
                    b_rdata_d = ram_out;
                    b_valid_d = 1'b1;
                end else begin
                    a_rdata_d = ram_out;
                    a_valid_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any access in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            prio_a_q     <= 1'b1;
            win_b_q      <= 1'b0;
            a_gnt_q      <= 1'b0;
            b_gnt_q      <= 1'b0;
            a_valid_q    <= 1'b0;
            b_valid_q    <= 1'b0;
            a_rdata_q    <= '0;
            b_rdata_q    <= '0;
            ram_enable_q <= 1'b0;
            ram_rw_q     <= 1'b0;
            ram_adr_q    <= '0;
            ram_in_q     <= '0;
        end else begin
            state_q      <= state_d;
            prio_a_q     <= prio_a_d;
            win_b_q      <= win_b_d;
            a_gnt_q      <= a_gnt_d;
            b_gnt_q      <= b_gnt_d;
            a_valid_q    <= a_valid_d;
            b_valid_q    <= b_valid_d;
            a_rdata_q    <= a_rdata_d;
            b_rdata_q    <= b_rdata_d;
            ram_enable_q <= ram_enable_d;
            ram_rw_q     <= ram_rw_d;
            ram_adr_q    <= ram_adr_d;
            ram_in_q     <= ram_in_d;
        end
    end

    assign a_gnt      = a_gnt_q;
    assign b_gnt      = b_gnt_q;
    assign a_valid    = a_valid_q;
    assign b_valid    = b_valid_q;
    assign a_rdata    = a_rdata_q;
    assign b_rdata    = b_rdata_q;
    assign ram_enable = ram_enable_q;
    assign ram_rw     = ram_rw_q;
    assign ram_adr    = ram_adr_q;
    assign ram_in     = ram_in_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed scenarios followed by a randomized phase checked
// against a transaction-level model (arbitration rule, access timing budget,
// reference memory). Honours RAM_ARB_BOOT_LOCK_EN when compiled with it.
module tb_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       boot = 1'b0;
    logic       a_req = 1'b0, a_rw = 1'b0;
    logic [7:0] a_adr = 8'h00, a_wdata = 8'h00;
    logic       b_req = 1'b0, b_rw = 1'b0;
    logic [7:0] b_adr = 8'h00, b_wdata = 8'h00;
    logic       a_gnt, a_valid, b_gnt, b_valid;
    logic [7:0] a_rdata, b_rdata;
    logic       ram_enable, ram_rw;
    logic [7:0] ram_adr, ram_in;
    logic [7:0] ram_out = 8'h00;

    logic [7:0] mem [256] = '{default: 8'h00};
    logic [7:0] ref_mem [256] = '{default: 8'h00};

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .boot(boot),
        .a_req(a_req), .a_rw(a_rw), .a_adr(a_adr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_valid(a_valid), .a_rdata(a_rdata),
        .b_req(b_req), .b_rw(b_rw), .b_adr(b_adr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_valid(b_valid), .b_rdata(b_rdata),
        .ram_enable(ram_enable), .ram_rw(ram_rw), .ram_adr(ram_adr),
        .ram_in(ram_in), .ram_out(ram_out)
    );

    // synchronous RAM: read data appears the cycle after the strobe
    always @(posedge clk) begin
        if (ram_enable) begin
            if (ram_rw) mem[ram_adr] <= ram_in;
            else        ram_out <= mem[ram_adr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_a_gnt"}, a_gnt, 0);
        check({tag, "_b_gnt"}, b_gnt, 0);
        check({tag, "_a_valid"}, a_valid, 0);
        check({tag, "_b_valid"}, b_valid, 0);
        check({tag, "_ram_enable"}, ram_enable, 0);
        check({tag, "_ram_rw"}, ram_rw, 0);
        check({tag, "_ram_adr"}, ram_adr, 0);
        check({tag, "_ram_in"}, ram_in, 0);
        check({tag, "_a_rdata"}, a_rdata, 0);
        check({tag, "_b_rdata"}, b_rdata, 0);
    endtask

    // model state for the randomized phase
    int         edge_n, free_at, a_due, b_due, txn;
    logic       last_b, exp_a, exp_b, s_b_elig;
    logic [7:0] a_exp, b_exp, a_last, b_last;
    logic       s_a_req, s_a_rw, s_b_req, s_b_rw, s_boot, w_rw;
    logic [7:0] s_a_adr, s_a_wd, s_b_adr, s_b_wd, w_adr, w_wd;
    logic [4:0] pat;

    initial begin
        // ---------------- reset state ----------------
        tick();
        tick();
        check_all_zero("reset");
        rst_n = 1'b1;

        // ---------------- A write 0x10 <- 0xA5 ----------------
        a_req = 1'b1; a_rw = 1'b1; a_adr = 8'h10; a_wdata = 8'hA5;
        tick();
        check("wr_a_gnt", a_gnt, 1);
        check("wr_b_gnt", b_gnt, 0);
        check("wr_enable", ram_enable, 1);
        check("wr_rw", ram_rw, 1);
        check("wr_adr", ram_adr, 8'h10);
        check("wr_in", ram_in, 8'hA5);
        $display("txn: A write adr=10 data=a5");
        a_req = 1'b0;
        tick();
        check("wr_enable_off", ram_enable, 0);
        check("wr_gnt_off", a_gnt, 0);
        check("wr_adr_hold", ram_adr, 8'h10);

        // ---------------- B read 0x10 ----------------
        b_req = 1'b1; b_rw = 1'b0; b_adr = 8'h10; b_wdata = 8'h00;
        tick();
        check("rd_b_gnt", b_gnt, 1);
        check("rd_rw", ram_rw, 0);
        b_req = 1'b0;
        tick();
        check("rd_b_valid_early", b_valid, 0);
        tick();
        check("rd_b_valid", b_valid, 1);
        check("rd_a_valid", a_valid, 0);
        check("rd_b_rdata", b_rdata, 8'hA5);
        $display("txn: B read adr=10 data=%h", b_rdata);
        tick();
        check("rd_b_valid_off", b_valid, 0);
        check("rd_b_rdata_hold", b_rdata, 8'hA5);

        // ---------------- async reset, then continuous A/B ----------------
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        tick();
        rst_n = 1'b1;
        a_req = 1'b1; a_rw = 1'b1; a_adr = 8'h20; a_wdata = 8'h11;
        b_req = 1'b1; b_rw = 1'b1; b_adr = 8'h21; b_wdata = 8'h22;
        for (int g = 0; g < 4; g++) begin
            tick();
            check("alt_a_gnt", a_gnt, (g % 2 == 0));
            check("alt_b_gnt", b_gnt, (g % 2 == 1));
            check("alt_enable", ram_enable, 1);
            $display("txn: alternate grant %0d a=%0b b=%0b", g, a_gnt, b_gnt);
            tick();
            check("alt_gap", a_gnt | b_gnt | ram_enable, 0);
        end

        // ---------------- boot lock ----------------
        boot = 1'b1;
`ifdef RAM_ARB_BOOT_LOCK_EN
        pat = 5'b10000;   // bit g: B expected on grant g
`else
        pat = 5'b01010;
`endif
        for (int g = 0; g < 5; g++) begin
            tick();
            check("boot_a_gnt", a_gnt, !pat[g]);
            check("boot_b_gnt", b_gnt, pat[g]);
            $display("txn: boot phase grant %0d a=%0b b=%0b", g, a_gnt, b_gnt);
            if (g == 4) begin
                a_req = 1'b0;
                b_req = 1'b0;
            end
            tick();
            check("boot_gap", a_gnt | b_gnt, 0);
            if (g == 3) boot = 1'b0;
        end

        // ---------------- reset during READ of a B read ----------------
        b_req = 1'b1; b_rw = 1'b0; b_adr = 8'h10;
        tick();
        check("rstrd_b_gnt", b_gnt, 1);
        b_req = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check_all_zero("rstrd");
        tick();
        check("rstrd_b_valid1", b_valid, 0);
        tick();
        check("rstrd_b_valid2", b_valid, 0);
        rst_n = 1'b1;
        a_req = 1'b1; a_rw = 1'b1; a_adr = 8'h40; a_wdata = 8'h44;
        b_req = 1'b1; b_rw = 1'b1; b_adr = 8'h41; b_wdata = 8'h55;
        tick();
        check("rstrd_first_a", a_gnt, 1);
        check("rstrd_first_b", b_gnt, 0);
        a_req = 1'b0; b_req = 1'b0;
        tick();
        check("rstrd_b_valid3", b_valid, 0);

        // ---------------- boot rises during B ACCESS ----------------
        b_req = 1'b1; b_rw = 1'b1; b_adr = 8'h30; b_wdata = 8'h5A;
        tick();
        check("bootmid_b_gnt", b_gnt, 1);
        check("bootmid_enable", ram_enable, 1);
        check("bootmid_adr", ram_adr, 8'h30);
        boot = 1'b1;
        a_req = 1'b1; a_rw = 1'b1; a_adr = 8'h31; a_wdata = 8'h66;
        b_req = 1'b0;
        tick();
        check("bootmid_mem", mem[8'h30], 8'h5A);
        check("bootmid_idle", ram_enable, 0);
        tick();
        check("bootmid_a_gnt", a_gnt, 1);
        check("bootmid_b_gnt", b_gnt, 0);
        $display("txn: A write after boot rise adr=31");
        a_req = 1'b0; boot = 1'b0;
        tick();

        // ---------------- randomized phase vs. transaction model ----------------
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        edge_n = 0; free_at = 1; last_b = 1'b1; a_due = -1; b_due = -1;
        a_last = 8'h00; b_last = 8'h00; txn = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            s_a_req = a_req; s_a_rw = a_rw; s_a_adr = a_adr; s_a_wd = a_wdata;
            s_b_req = b_req; s_b_rw = b_rw; s_b_adr = b_adr; s_b_wd = b_wdata;
            s_boot = boot;
            tick();
            edge_n++;

            check("rnd_a_valid", a_valid, (a_due == edge_n));
            if (a_due == edge_n) a_last = a_exp;
            check("rnd_a_rdata", a_rdata, a_last);
            check("rnd_b_valid", b_valid, (b_due == edge_n));
            if (b_due == edge_n) b_last = b_exp;
            check("rnd_b_rdata", b_rdata, b_last);

`ifdef RAM_ARB_BOOT_LOCK_EN
            s_b_elig = s_b_req && !s_boot;
`else
            s_b_elig = s_b_req;
`endif
            exp_a = 1'b0; exp_b = 1'b0;
            if (edge_n >= free_at) begin
                if (s_a_req && s_b_elig) begin
                    exp_a = last_b;
                    exp_b = !last_b;
                end else begin
                    exp_a = s_a_req;
                    exp_b = s_b_elig;
                end
            end
            check("rnd_a_gnt", a_gnt, exp_a);
            check("rnd_b_gnt", b_gnt, exp_b);
            check("rnd_enable", ram_enable, exp_a | exp_b);

            if (exp_a || exp_b) begin
                w_rw  = exp_b ? s_b_rw  : s_a_rw;
                w_adr = exp_b ? s_b_adr : s_a_adr;
                w_wd  = exp_b ? s_b_wd  : s_a_wd;
                check("rnd_rw", ram_rw, w_rw);
                check("rnd_adr", ram_adr, w_adr);
                check("rnd_in", ram_in, w_wd);
                last_b = exp_b;
                txn++;
                $display("txn %0d: port %s %s adr=%h data=%h", txn, exp_b ? "B" : "A",
                         w_rw ? "write" : "read", w_adr, w_rw ? w_wd : ref_mem[w_adr]);
                if (w_rw) begin
                    ref_mem[w_adr] = w_wd;
                    free_at = edge_n + 2;
                end else begin
                    if (exp_b) begin b_due = edge_n + 2; b_exp = ref_mem[w_adr]; end
                    else       begin a_due = edge_n + 2; a_exp = ref_mem[w_adr]; end
                    free_at = edge_n + 3;
                end
                if (exp_a) a_req = 1'b0;
                if (exp_b) b_req = 1'b0;
            end

            if (!a_req && $urandom_range(0, 2) == 0) begin
                a_req = 1'b1; a_rw = 1'($urandom_range(0, 1));
                a_adr = 8'h80 | 8'($urandom_range(0, 15)); a_wdata = 8'($urandom);
            end
            if (!b_req && $urandom_range(0, 2) == 0) begin
                b_req = 1'b1; b_rw = 1'($urandom_range(0, 1));
                b_adr = 8'h80 | 8'($urandom_range(0, 15)); b_wdata = 8'($urandom);
            end
            if ($urandom_range(0, 19) == 0) boot = ~boot;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
